// File: rtl/fphub_mult_pipe_pkg.sv
// Shared helpers for the HUB multiplier: exponent bias, field positions and flag layout.
package fphub_pkg;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic special;
  } fphub_flags_t;

  // HUB formats use a bias of 2^(E-1), not the IEEE 2^(E-1)-1.
  function automatic int unsigned fphub_bias(input int unsigned e);
    return 32'd1 << (e - 32'd1);
  endfunction

  function automatic int unsigned fphub_sign_pos(input int unsigned m, input int unsigned e);
    return m + e;
  endfunction

  function automatic int unsigned fphub_exp_lsb(input int unsigned m);
    return m;
  endfunction

endpackage

// File: rtl/fphub_mult_pipe_if.sv
// Operand/result handshake bundle for fphub_mult_pipe.
interface fphub_mult_pipe_if #(
  parameter int unsigned M     = 23,
  parameter int unsigned E     = 8,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [E+M:0]     in_x;
  logic [E+M:0]     in_y;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [E+M:0]     out_z;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       out_flags;

  modport master (
    output in_valid, in_x, in_y, in_tag, out_ready,
    input  in_ready, out_valid, out_z, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_x, in_y, in_tag, out_ready,
    output in_ready, out_valid, out_z, out_tag, out_flags
  );
endinterface

// File: rtl/fphub_sig_mul.sv
// Unsigned combinational significand multiplier used by the S2 stage.
module fphub_sig_mul #(
  parameter int unsigned SW = 25
) (
  input  logic [SW-1:0]   a_i,
  input  logic [SW-1:0]   b_i,
  output logic [2*SW-1:0] p_o
);
  always_comb begin
    p_o = {{SW{1'b0}}, a_i} * {{SW{1'b0}}, b_i};
  end
endmodule

// File: rtl/fphub_mult_pipe.sv
// Three-stage HUB floating-point multiplier: unpack/special detect, significand
// multiply, normalize/pack. A single advance signal stalls or shifts all stages.
module fphub_mult_pipe
  import fphub_pkg::*;
#(
  parameter int unsigned M     = 23,
  parameter int unsigned E     = 8,
  parameter int unsigned TAG_W = 4
) (
  input logic              clk,
  input logic              rst,
  fphub_mult_pipe_if.slave bus
);

  localparam int unsigned W        = E + M + 1;
  localparam int unsigned SW       = M + 2;
  localparam int unsigned PW       = 2 * SW;
  localparam int unsigned SIGN_POS = fphub_sign_pos(M, E);
  localparam int unsigned EXP_LSB  = fphub_exp_lsb(M);

  localparam logic signed [E+1:0] BIAS_S = (E+2)'(fphub_bias(E));
  localparam logic signed [E+1:0] EMAX_S = (E+2)'((32'd1 << E) - 32'd1);

  typedef struct packed {
    logic             sign;
    logic [E-1:0]     ex;
    logic [E-1:0]     ey;
    logic [M-1:0]     mx;
    logic [M-1:0]     my;
    logic             zero;
    logic             inf;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic               sign;
    logic signed [E+1:0] ez_base;
    logic [PW-1:0]      prod;
    logic               zero;
    logic               inf;
    logic [TAG_W-1:0]   tag;
  } s2_t;

  typedef struct packed {
    logic [W-1:0]     z;
    fphub_flags_t     flags;
    logic [TAG_W-1:0] tag;
  } s3_t;

  logic v1_q, v2_q, v3_q;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  s3_t  s3_q, s3_d;
  logic advance;

  logic [E-1:0]      in_ex, in_ey;
  logic [SW-1:0]     sig_x, sig_y;
  logic [PW-1:0]     prod;
  logic              norm;
  logic [M-1:0]      man;
  logic signed [E+1:0] ez;

  assign advance = ~v3_q | bus.out_ready;

  // S1: unpack and classify operands
  always_comb begin
    in_ex     = bus.in_x[EXP_LSB +: E];
    in_ey     = bus.in_y[EXP_LSB +: E];
    s1_d      = '0;
    s1_d.sign = bus.in_x[SIGN_POS] ^ bus.in_y[SIGN_POS];
    s1_d.ex   = in_ex;
    s1_d.ey   = in_ey;
    s1_d.mx   = bus.in_x[M-1:0];
    s1_d.my   = bus.in_y[M-1:0];
    s1_d.zero = (in_ex == '0) | (in_ey == '0);
    s1_d.inf  = (in_ex == '1) | (in_ey == '1);
    s1_d.tag  = bus.in_tag;
  end

  // S2: significand product with both implicit ones, plus unbiased exponent sum
  always_comb begin
    sig_x = {1'b1, s1_q.mx, 1'b1};
    sig_y = {1'b1, s1_q.my, 1'b1};
  end

  fphub_sig_mul #(.SW(SW)) u_sig_mul (
    .a_i (sig_x),
    .b_i (sig_y),
    .p_o (prod)
  );

  always_comb begin
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.ez_base = $signed({2'b00, s1_q.ex}) + $signed({2'b00, s1_q.ey}) - BIAS_S;
    s2_d.prod    = prod;
    s2_d.zero    = s1_q.zero;
    s2_d.inf     = s1_q.inf;
    s2_d.tag     = s1_q.tag;
  end

  // S3: normalize by at most one place; truncation is the HUB rounding
  always_comb begin
    norm = s2_q.prod[PW-1];
    man  = norm ? s2_q.prod[PW-2 -: M] : s2_q.prod[PW-3 -: M];
    ez   = s2_q.ez_base + $signed({{(E+1){1'b0}}, norm});

    s3_d     = '0;
    s3_d.tag = s2_q.tag;
    if (s2_q.zero) begin
      s3_d.flags.special = 1'b1;
    end else if (s2_q.inf) begin
      s3_d.z             = {s2_q.sign, {(W-1){1'b1}}};
      s3_d.flags.special = 1'b1;
    end else if (ez >= EMAX_S) begin
      s3_d.z         = {s2_q.sign, {(W-1){1'b1}}};
      s3_d.flags.ovf = 1'b1;
    end else if (ez <= $signed((E+2)'(0))) begin
      s3_d.flags.unf = 1'b1;
    end else begin
      s3_d.z = {s2_q.sign, ez[E-1:0], man};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (advance) begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // Outputs are forced to their idle values for the whole reset cycle.
  always_comb begin
    bus.in_ready  = rst | advance;
    bus.out_valid = v3_q & ~rst;
    bus.out_z     = rst ? '0 : s3_q.z;
    bus.out_tag   = rst ? '0 : s3_q.tag;
    bus.out_flags = rst ? '0 : s3_q.flags;
  end

endmodule

// File: tb/tb_fphub_mult_pipe.sv
// Randomized and directed bench for fphub_mult_pipe with an arithmetic reference model.
module tb_fphub_mult_pipe;
  localparam int unsigned M     = 23;
  localparam int unsigned E     = 8;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned W     = E + M + 1;

  typedef struct {
    logic [W-1:0]     z;
    logic [TAG_W-1:0] tag;
    logic [2:0]       f;
    int               acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fphub_mult_pipe_if #(.M(M), .E(E), .TAG_W(TAG_W)) bus ();

  fphub_mult_pipe #(.M(M), .E(E), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit lat_check = 1'b0;
  bit head_seen = 1'b0;
  bit was_held  = 1'b0;
  logic [W-1:0]     hz;
  logic [TAG_W-1:0] ht;
  logic [2:0]       hf;
  exp_t q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: real-valued HUB product via integer arithmetic and leading-one search.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] z, output logic [2:0] f);
    int ex, ey, ez, lead;
    int emax;
    longint unsigned sx, sy, p;
    logic [M-1:0] man;
    logic [E-1:0] ezf;
    logic s;
    emax = (1 << E) - 1;
    ex = int'(x[M +: E]);
    ey = int'(y[M +: E]);
    s  = x[W-1] ^ y[W-1];
    z  = '0;
    f  = 3'b000;
    if (ex == 0 || ey == 0) begin
      f = 3'b001;
    end else if (ex == emax || ey == emax) begin
      z = {s, {(W-1){1'b1}}};
      f = 3'b001;
    end else begin
      sx = (64'd1 << (M + 1)) | (64'(x[M-1:0]) << 1) | 64'd1;
      sy = (64'd1 << (M + 1)) | (64'(y[M-1:0]) << 1) | 64'd1;
      p  = sx * sy;
      lead = 0;
      for (int b = 0; b < 64; b++) if (p[b]) lead = b;
      man = M'(p >> (lead - int'(M)));
      ez  = ex + ey - (1 << (E - 1)) + ((lead == int'(2 * M + 3)) ? 1 : 0);
      if (ez >= emax) begin
        z = {s, {(W-1){1'b1}}};
        f = 3'b100;
      end else if (ez <= 0) begin
        f = 3'b010;
      end else begin
        ezf = E'(ez);
        z = {s, ezf, man};
      end
    end
  endfunction

  task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [TAG_W-1:0] tg, input logic ordy, input logic r,
                      input bit use_exp, input logic [W-1:0] xz, input logic [2:0] xf,
                      output bit fired);
    exp_t e;
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.in_x      = x;
    bus.in_y      = y;
    bus.in_tag    = tg;
    bus.out_ready = ordy;
    #1;
    fired = 1'b0;
    if (r) begin
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check_eq("rst_out_z", 64'(bus.out_z), 64'd0);
      check_eq("rst_out_tag", 64'(bus.out_tag), 64'd0);
      check_eq("rst_out_flags", 64'(bus.out_flags), 64'd0);
      q.delete();
      head_seen = 1'b0;
      was_held  = 1'b0;
    end else begin
      check_eq("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || ordy));
      if (was_held) begin
        check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
        check_eq("hold_z", 64'(bus.out_z), 64'(hz));
        check_eq("hold_tag", 64'(bus.out_tag), 64'(ht));
        check_eq("hold_flags", 64'(bus.out_flags), 64'(hf));
      end
      if (q.size() == 0) begin
        check_eq("idle_valid", 64'(bus.out_valid), 64'd0);
      end else if (bus.out_valid) begin
        if (!head_seen) begin
          head_seen = 1'b1;
          if (lat_check) check_eq("latency", 64'(cyc - q[0].acc), 64'd3);
        end
        if (ordy) begin
          e = q.pop_front();
          check_eq("out_z", 64'(bus.out_z), 64'(e.z));
          check_eq("out_tag", 64'(bus.out_tag), 64'(e.tag));
          check_eq("out_flags", 64'(bus.out_flags), 64'(e.f));
          head_seen = 1'b0;
        end
      end
      was_held = bus.out_valid && !ordy;
      hz = bus.out_z;
      ht = bus.out_tag;
      hf = bus.out_flags;
      if (v && bus.in_ready) begin
        fired = 1'b1;
        if (use_exp) begin
          e.z = xz;
          e.f = xf;
        end else begin
          model(x, y, e.z, e.f);
        end
        e.tag = tg;
        e.acc = cyc;
        q.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [TAG_W-1:0] tg,
                      input bit use_exp, input logic [W-1:0] xz, input logic [2:0] xf);
    bit fired;
    fired = 1'b0;
    for (int n = 0; n < 50 && !fired; n++) step(1'b1, x, y, tg, 1'b1, 1'b0, use_exp, xz, xf, fired);
    if (!fired) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    bit fired;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0, fired);
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [E-1:0] e;
    logic [M-1:0] m;
    logic s;
    int sel;
    sel = int'($urandom_range(0, 9));
    s   = 1'($urandom_range(0, 1));
    m   = M'($urandom);
    case (sel)
      0:       e = '0;
      1:       e = '1;
      2:       e = E'($urandom_range(1, 8));
      3:       e = E'($urandom_range((1 << E) - 9, (1 << E) - 2));
      4:       e = E'($urandom_range((1 << (E - 2)), (1 << (E - 1)) - 1));
      default: e = E'($urandom_range(0, (1 << E) - 1));
    endcase
    return {s, e, m};
  endfunction

  initial begin
    bit fired;
    int k, i;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, '0, '0, fired);
    step(1'b1, 32'h4000_0000, 32'h4000_0000, 4'd7, 1'b1, 1'b1, 1'b0, '0, '0, fired);

    // Directed corner products with hand-derived results, free-flowing output
    lat_check = 1'b1;
    send(32'h4000_0000, 32'h4000_0000, 4'd3, 1'b1, 32'h4000_0001, 3'b000);
    idle(4);
    send(32'h4080_0000, 32'h4080_0000, 4'd1, 1'b1, 32'h4100_0001, 3'b000);
    send(32'h7F00_0000, 32'h7F00_0000, 4'd2, 1'b1, 32'h7FFF_FFFF, 3'b100);
    send(32'h0300_0000, 32'h8300_0000, 4'd4, 1'b1, 32'h0000_0000, 3'b010);
    send(32'h0000_0000, 32'hFFFF_FFFF, 4'd5, 1'b1, 32'h0000_0000, 3'b001);
    send(32'h7F80_0000, 32'h4000_0000, 4'd6, 1'b1, 32'h7FFF_FFFF, 3'b001);
    send(32'hFF80_0000, 32'h4000_0000, 4'd8, 1'b1, 32'hFFFF_FFFF, 3'b001);
    idle(5);

    // Six back-to-back ops with the consumer stalled for cycles 4..9
    lat_check = 1'b0;
    i = 0;
    for (k = 0; k < 60 && !(i == 6 && q.size() == 0); k++) begin
      step(i < 6, rand_op(), rand_op(), TAG_W'(i), !(k >= 4 && k <= 9), 1'b0, 1'b0, '0, '0, fired);
      if (fired) i++;
    end
    check_eq("bp_accepted", 64'(i), 64'd6);
    check_eq("bp_drained", 64'(q.size()), 64'd0);

    // Reset with three ops in flight; an input offered during reset must be dropped
    lat_check = 1'b1;
    send(32'h4000_0000, 32'h4080_0000, 4'd9, 1'b0, '0, '0);
    send(32'h4080_0000, 32'h4080_0000, 4'd10, 1'b0, '0, '0);
    send(32'hC000_0000, 32'h4080_0000, 4'd11, 1'b0, '0, '0);
    step(1'b1, 32'h4000_0000, 32'h4000_0000, 4'd12, 1'b1, 1'b1, 1'b0, '0, '0, fired);
    idle(6);
    send(32'h4123_4567, 32'hC0AB_CDEF, 4'd13, 1'b0, '0, '0);
    idle(4);
    check_eq("post_rst_drained", 64'(q.size()), 64'd0);

    // Random traffic with random backpressure
    lat_check = 1'b0;
    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 3) != 0, rand_op(), rand_op(), TAG_W'($urandom),
           $urandom_range(0, 3) != 0, 1'b0, 1'b0, '0, '0, fired);
    end
    for (int n = 0; n < 50 && q.size() != 0; n++) idle(1);
    check_eq("rand_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fphub_mult_pipe.md
FPHUB_MULT_PIPE -- requirements
Module: fphub_mult_pipe

Interface
REQ-001 Parameter M, default 23: explicit mantissa field width.
REQ-002 Parameter E, default 8: exponent field width; bias SHALL be 2^(E-1).
REQ-003 Parameter TAG_W, default 4: width of the user tag carried with each operation.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port in_valid  input  1: operand pair present.
REQ-007 Port in_ready  output  1: block accepts operands this cycle.
REQ-008 Port in_x, in_y  input  E+M+1 each: HUB operands, layout {sign, exp[E-1:0], man[M-1:0]}.
REQ-009 Port in_tag  input  TAG_W: tag returned with the result.
REQ-010 Port out_valid  output  1: result present.
REQ-011 Port out_ready  input  1: consumer accepts result.
REQ-012 Port out_z  output  E+M+1: HUB product.
REQ-013 Port out_tag  output  TAG_W: tag of the product on out_z.
REQ-014 Port out_flags  output  3: {ovf, unf, special}; special = an operand was zero or inf.

Function
REQ-015 Transfer on a port occurs only when valid and ready are both high in the same cycle.
REQ-016 Pipeline SHALL be 3 stages: S1 unpack/special detect, S2 significand multiply, S3 normalize/pack. Each stage has a valid bit v1..v3.
REQ-017 advance = !v3 | out_ready. in_ready = advance. When advance is high, all stages shift one place and S1 loads the accepted input, or a bubble. When advance is low, every stage holds.
REQ-018 Latency: an operation accepted in cycle t appears on out_valid in cycle t+3 when advance stays high. Throughput: 1 operation per cycle.
REQ-019 Results SHALL leave in acceptance order. out_z, out_tag and out_flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 HUB significand = {1, man, 1} (M+2 bits: implicit leading one and implicit LSB). Product is 2M+4 bits wide.
REQ-021 Normalization: if the product MSB is 1, set norm=1. Result man = the M bits immediately below the leading one, truncated. Truncation is the HUB round-to-nearest; no rounding adder is used.
REQ-022 Ez = Ex + Ey - 2^(E-1) + norm, computed signed with E+2 bits.
REQ-023 Result sign = sx XOR sy.
REQ-024 If Ez >= 2^E-1, result = {sign, all-ones exp, all-ones man} and ovf=1.
REQ-025 If Ez <= 0, result = all-zero word (+0) and unf=1.
REQ-026 An operand with exp field 0 is zero; an operand with all-ones exp is inf.
REQ-027 Special-case priority: any zero operand gives +0 (this includes inf*0). Otherwise any inf operand gives {sign, all ones}. special=1 in both cases. ovf and unf are 0 for special cases.

Reset
REQ-028 While rst=1: v1, v2, v3 = 0; out_valid = 0; out_z, out_tag, out_flags = 0; in_ready = 1.
REQ-029 rst asserted mid-operation discards all in-flight operations. No output is produced for them after rst deasserts.
REQ-030 An input presented during the rst cycle is not accepted.

Structure
REQ-031 Package fphub_pkg holds the bias function, field-slice constants and a stage-payload struct typedef parameterised by M, E.
REQ-032 The significand product SHALL be in sub-module fphub_sig_mul: combinational (M+2)x(M+2) unsigned multiplier, instantiated in S2.
REQ-033 Size target: 120-400 lines RTL.

Verification (M=23, E=8)
REQ-034 0x40000000 * 0x40000000 (1.0*1.0), tag 3 -> 0x40000001, flags 000, tag 3, exactly 3 cycles after accept.
REQ-035 0x40800000 * 0x40800000 (2.0*2.0) -> 0x41000001. Then 0x7F000000 * 0x7F000000 -> 0x7FFFFFFF, ovf=1.
REQ-036 0x03000000 * 0x83000000 -> 0x00000000, unf=1. 0x00000000 * 0xFFFFFFFF -> 0x00000000, special=1.
REQ-037 Backpressure: stream 6 ops with tags 0..5 back-to-back, out_ready=0 for cycles 4..9 -> in_ready=0 while v3=1 and out_ready=0; outputs held stable; all 6 results delivered in tag order 0..5, none lost or duplicated.
REQ-038 rst pulsed one cycle with 3 ops in flight -> out_valid=0 next cycle; no stale result later; next accepted op is output after 3 cycles.
